// File: rtl/multi_cycle_control_pkg.sv
// ============================================================================
// multi_cycle_control_pkg : state encodings, opcodes, ALU/mux codes, control bundle
// Revision: 1.0
// ============================================================================
`default_nettype none

package multi_cycle_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REXEC  = 4'd6,
    S_RWB    = 4'd7,
    S_BEQ    = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } aluop_e;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_BRANCH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    aluop_e     alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctrl_t;

  // First execution state reached from DECODE; S_FETCH marks an unsupported opcode.
  function automatic state_e decode_target(input logic [5:0] op);
    case (op)
      OP_LW, OP_SW: decode_target = S_MEMADR;
      OP_RTYPE:     decode_target = S_REXEC;
      OP_BEQ:       decode_target = S_BEQ;
      OP_ADDI:      decode_target = S_ADDIEX;
      OP_J:         decode_target = S_JUMP;
      default:      decode_target = S_FETCH;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mc_output_decode.sv
// ============================================================================
// mc_output_decode : maps the current state to the datapath control bundle
// Revision: 1.0
// ============================================================================
`default_nettype none

module mc_output_decode
  import multi_cycle_control_pkg::*;
(
  input  state_e state_i,
  input  logic   mem_ready_i,
  input  logic   reset_i,
  input  logic   op_illegal_i,
  output ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    if (reset_i) begin
      // Only the fixed FETCH selects survive reset; no strobes, no memory request.
      ctrl_o.alu_src_b = SRCB_FOUR;
    end else begin
      case (state_i)
        S_FETCH: begin
          ctrl_o.mem_read  = 1'b1;
          ctrl_o.alu_src_b = SRCB_FOUR;
          ctrl_o.ir_write  = mem_ready_i;
          ctrl_o.pc_write  = mem_ready_i;
        end
        S_DECODE: begin
          ctrl_o.alu_src_b  = SRCB_BRANCH;
          ctrl_o.illegal_op = op_illegal_i;
        end
        S_MEMADR: begin
          ctrl_o.alu_src_a = 1'b1;
          ctrl_o.alu_src_b = SRCB_IMM;
        end
        S_MEMRD: begin
          ctrl_o.mem_read = 1'b1;
          ctrl_o.iord     = 1'b1;
        end
        S_MEMWB: begin
          ctrl_o.reg_write  = 1'b1;
          ctrl_o.mem_to_reg = 1'b1;
        end
        S_MEMWR: begin
          ctrl_o.mem_write = 1'b1;
          ctrl_o.iord      = 1'b1;
        end
        S_REXEC: begin
          ctrl_o.alu_src_a = 1'b1;
          ctrl_o.alu_src_b = SRCB_REG;
          ctrl_o.alu_op    = ALU_FUNCT;
        end
        S_RWB: begin
          ctrl_o.reg_write = 1'b1;
          ctrl_o.reg_dst   = 1'b1;
        end
        S_BEQ: begin
          ctrl_o.alu_src_a     = 1'b1;
          ctrl_o.alu_src_b     = SRCB_REG;
          ctrl_o.alu_op        = ALU_SUB;
          ctrl_o.pc_write_cond = 1'b1;
          ctrl_o.pc_source     = PCSRC_ALUOUT;
        end
        S_ADDIEX: begin
          ctrl_o.alu_src_a = 1'b1;
          ctrl_o.alu_src_b = SRCB_IMM;
        end
        S_ADDIWB: begin
          ctrl_o.reg_write = 1'b1;
        end
        S_JUMP: begin
          ctrl_o.pc_write  = 1'b1;
          ctrl_o.pc_source = PCSRC_JUMP;
        end
        default: ctrl_o = '0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/multi_cycle_control.sv
// ============================================================================
// multi_cycle_control : Moore control FSM for a multi-cycle MIPS-style datapath
// Revision: 1.0
// ============================================================================
`default_nettype none

module multi_cycle_control
  import multi_cycle_control_pkg::*;
#(
  parameter int OPC_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OPC_W-1:0] opcode,
  input  logic             memReady,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             IRWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemToReg,
  output logic             RegDST,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       AluOp,
  output logic [1:0]       PCSource,
  output logic             illegalOp,
  output logic [3:0]       state
);

  state_e      state_q;
  state_e      state_d;
  logic [5:0]  op6_w;
  logic        op_hi_zero_w;
  state_e      target_w;
  logic        is_lw_w;
  ctrl_t       ctrl_w;

  // Opcodes wider than six bits are only recognised when the extra bits are zero.
  generate
    if (OPC_W > 6) begin : g_opc_wide
      assign op6_w        = opcode[5:0];
      assign op_hi_zero_w = ~|opcode[OPC_W-1:6];
    end else begin : g_opc_fit
      assign op6_w        = 6'(opcode);
      assign op_hi_zero_w = 1'b1;
    end
  endgenerate

  assign target_w = op_hi_zero_w ? decode_target(op6_w) : S_FETCH;
  assign is_lw_w  = op_hi_zero_w && (op6_w == OP_LW);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = memReady ? S_DECODE : S_FETCH;
      S_DECODE: state_d = target_w;
      S_MEMADR: state_d = is_lw_w ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = memReady ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = memReady ? S_FETCH : S_MEMWR;
      S_REXEC:  state_d = S_RWB;
      S_RWB:    state_d = S_FETCH;
      S_BEQ:    state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  mc_output_decode u_output_decode (
    .state_i      (state_q),
    .mem_ready_i  (memReady),
    .reset_i      (reset),
    .op_illegal_i (target_w == S_FETCH),
    .ctrl_o       (ctrl_w)
  );

  assign PCWrite     = ctrl_w.pc_write;
  assign PCWriteCond = ctrl_w.pc_write_cond;
  assign IorD        = ctrl_w.iord;
  assign IRWrite     = ctrl_w.ir_write;
  assign MemRead     = ctrl_w.mem_read;
  assign MemWrite    = ctrl_w.mem_write;
  assign MemToReg    = ctrl_w.mem_to_reg;
  assign RegDST      = ctrl_w.reg_dst;
  assign RegWrite    = ctrl_w.reg_write;
  assign ALUSrcA     = ctrl_w.alu_src_a;
  assign ALUSrcB     = ctrl_w.alu_src_b;
  assign AluOp       = ctrl_w.alu_op;
  assign PCSource    = ctrl_w.pc_source;
  assign illegalOp   = ctrl_w.illegal_op;
  assign state       = state_q;

endmodule

`default_nettype wire

// File: tb/tb_multi_cycle_control.sv
// ============================================================================
// tb_multi_cycle_control : scoreboard bench with an instruction-sequence model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_multi_cycle_control;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       memReady = 1'b0;
  logic       PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite;
  logic       MemToReg, RegDST, RegWrite, ALUSrcA, illegalOp;
  logic [1:0] ALUSrcB, AluOp, PCSource;
  logic [3:0] state;

  multi_cycle_control #(.OPC_W(6)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .memReady(memReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .IRWrite(IRWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg), .RegDST(RegDST),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .AluOp(AluOp),
    .PCSource(PCSource), .illegalOp(illegalOp), .state(state)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BQ = 6'b000100, AI = 6'b001000, JJ = 6'b000010;

  logic [20:0] exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          run = 1'b0;

  // Model: current step plus the list of steps the decoded instruction still owes.
  int          m_cur = 0;
  int          m_pend[$];

  // Packed view: state, 10 strobes, ALUSrcB, AluOp, PCSource, illegalOp.
  function automatic logic [20:0] exp_out(int s, bit mr, bit rst, bit ill);
    logic [20:0] c;
    c = '0;
    c[20:17] = 4'(s);
    if (rst) begin
      c[6:5] = 2'b01;
      return c;
    end
    case (s)
      0:  begin c[12] = 1'b1; c[6:5] = 2'b01; c[13] = mr; c[16] = mr; end
      1:  begin c[6:5] = 2'b11; c[0] = ill; end
      2:  begin c[7] = 1'b1; c[6:5] = 2'b10; end
      3:  begin c[12] = 1'b1; c[14] = 1'b1; end
      4:  begin c[8] = 1'b1; c[10] = 1'b1; end
      5:  begin c[11] = 1'b1; c[14] = 1'b1; end
      6:  begin c[7] = 1'b1; c[4:3] = 2'b10; end
      7:  begin c[8] = 1'b1; c[9] = 1'b1; end
      8:  begin c[7] = 1'b1; c[4:3] = 2'b01; c[15] = 1'b1; c[2:1] = 2'b01; end
      9:  begin c[7] = 1'b1; c[6:5] = 2'b10; end
      10: begin c[8] = 1'b1; end
      11: begin c[16] = 1'b1; c[2:1] = 2'b10; end
      default: c = c;
    endcase
    return c;
  endfunction

  function automatic bit is_legal(logic [5:0] op);
    return (op == LW) || (op == SW) || (op == RT) || (op == BQ) || (op == AI) || (op == JJ);
  endfunction

  function automatic int next_step();
    if (m_pend.size() > 0) return m_pend.pop_front();
    return 0;
  endfunction

  // One clock cycle: drive inputs, record the expected response, advance the model.
  task automatic cyc(input bit r, input bit m, input logic [5:0] op);
    @(posedge clk);
    #1;
    reset    = r;
    memReady = m;
    opcode   = op;
    exp_q.push_back(exp_out(m_cur, m, r, !is_legal(op)));
    if (r) begin
      m_cur = 0;
      m_pend.delete();
    end else begin
      case (m_cur)
        0: if (m) m_cur = 1;
        1: begin
          case (op)
            LW: begin m_pend.push_back(2); m_pend.push_back(3); m_pend.push_back(4); end
            SW: begin m_pend.push_back(2); m_pend.push_back(5); end
            RT: begin m_pend.push_back(6); m_pend.push_back(7); end
            BQ: m_pend.push_back(8);
            AI: begin m_pend.push_back(9); m_pend.push_back(10); end
            JJ: m_pend.push_back(11);
            default: m_pend.delete();
          endcase
          m_cur = next_step();
        end
        3, 5: if (m) m_cur = next_step();
        default: m_cur = next_step();
      endcase
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [20:0] act;
    logic [20:0] e;
    if (run) begin
      act = {state, PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite, MemToReg,
             RegDST, RegWrite, ALUSrcA, ALUSrcB, AluOp, PCSource, illegalOp};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL scoreboard_empty at %0t: got %h, required an expected entry", $time, act);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          n_bad++;
          $display("FAIL ctrl at %0t: actual %h required %h (state act %0d req %0d)",
                   $time, act, e, act[20:17], e[20:17]);
        end
      end
    end
  end

  initial begin
    logic [5:0] ops [6];
    logic [5:0] rop;
    ops[0] = LW; ops[1] = SW; ops[2] = RT; ops[3] = BQ; ops[4] = AI; ops[5] = JJ;
    rop = RT;
    run = 1'b1;

    repeat (2) cyc(1, 0, RT);
    repeat (5) cyc(0, 1, LW);                      // lw straight through
    repeat (3) cyc(0, 1, LW);                      // lw into MEMRD, stall, then reset
    repeat (2) cyc(0, 0, LW);
    cyc(1, 0, LW);
    repeat (3) cyc(0, 1, SW);                      // sw with three MEMWR stalls
    repeat (3) cyc(0, 0, SW);
    cyc(0, 1, SW);
    repeat (2) cyc(0, 0, RT);                      // FETCH stall, then R-type
    repeat (4) cyc(0, 1, RT);
    repeat (2) cyc(0, 1, 6'b000001);               // illegal opcodes
    repeat (2) cyc(0, 1, 6'b000101);
    repeat (3) cyc(0, 1, BQ);
    repeat (3) cyc(0, 1, JJ);
    repeat (4) cyc(0, 1, AI);

    for (int i = 0; i < 1500; i++) begin
      if (m_cur == 0) begin
        if ($urandom_range(0, 7) < 6) rop = ops[$urandom_range(0, 5)];
        else rop = 6'($urandom);
      end
      cyc(($urandom_range(0, 59) == 0), ($urandom_range(0, 9) < 7), rop);
    end

    @(negedge clk);
    #1;
    run = 1'b0;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multi_cycle_control.md
MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

Interface
REQ-001 SHALL have parameter OPC_W, default 6, opcode field width.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port opcode  input  OPC_W  instruction-register opcode field.
REQ-005 SHALL have port memReady  input  1  memory access complete this cycle.
REQ-006 SHALL have ports PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite, MemToReg, RegDST, RegWrite, ALUSrcA  output  1 each  datapath controls.
REQ-007 SHALL have ports ALUSrcB, AluOp, PCSource  output  2 each  datapath mux and ALU selects.
REQ-008 SHALL have port illegalOp  output  1  one-cycle pulse on an unsupported opcode.
REQ-009 SHALL have port state  output  4  current state encoding, for debug.

Function
REQ-010 SHALL implement a Moore FSM with states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, REXEC=6, RWB=7, BEQ=8, ADDIEX=9, ADDIWB=10, JUMP=11; encodings 12-15 SHALL go to FETCH.
REQ-011 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, AluOp=00, PCSource=00; IRWrite=PCWrite=memReady; holds while memReady=0; goes to DECODE when memReady=1.
REQ-012 DECODE: ALUSrcA=0, ALUSrcB=11, AluOp=00; next state by opcode: 100011 or 101011 -> MEMADR, 000000 -> REXEC, 000100 -> BEQ, 001000 -> ADDIEX, 000010 -> JUMP, any other -> FETCH with illegalOp=1 for that DECODE cycle only.
REQ-013 MEMADR: ALUSrcA=1, ALUSrcB=10, AluOp=00; opcode 100011 -> MEMRD, otherwise MEMWR.
REQ-014 MEMRD: MemRead=1, IorD=1; holds until memReady=1, then MEMWB.
REQ-015 MEMWB: RegWrite=1, MemToReg=1, RegDST=0; next FETCH.
REQ-016 MEMWR: MemWrite=1, IorD=1; holds until memReady=1, then FETCH; MemWrite SHALL stay asserted for every stall cycle.
REQ-017 REXEC: ALUSrcA=1, ALUSrcB=00, AluOp=10; next RWB. RWB: RegWrite=1, RegDST=1, MemToReg=0; next FETCH.
REQ-018 BEQ: ALUSrcA=1, ALUSrcB=00, AluOp=01, PCWriteCond=1, PCSource=01; next FETCH.
REQ-019 ADDIEX: ALUSrcA=1, ALUSrcB=10, AluOp=00; next ADDIWB. ADDIWB: RegWrite=1, RegDST=0, MemToReg=0; next FETCH.
REQ-020 JUMP: PCWrite=1, PCSource=10; next FETCH.
REQ-021 Every control not listed for a state SHALL be 0; outputs SHALL depend only on state, except FETCH IRWrite/PCWrite and the DECODE illegalOp.
REQ-022 memReady SHALL be ignored in all states except FETCH, MEMRD and MEMWR.
REQ-023 Instruction latency with memReady=1 throughout SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles.

Reset
REQ-024 reset=1 at a rising clk edge SHALL force state to FETCH on that edge, including mid-instruction and mid-stall, and overrides every transition.
REQ-025 While reset=1, all outputs SHALL be 0 except the fixed FETCH selects of REQ-011, and IRWrite/PCWrite SHALL be held at 0.

Structure
REQ-026 State encodings, opcode constants and AluOp codes (00 add, 01 sub, 10 funct) SHALL live in a shared package reused by the single-cycle controlUnit.
REQ-027 SHALL split into a next-state/state-register process and one sub-module, mc_output_decode, mapping state to control outputs.

Verification
REQ-028 lw (100011), memReady=1 -> states 0,1,2,3,4,0; RegWrite=1 and MemToReg=1 only in state 4.
REQ-029 sw (101011), memReady=0 for 3 cycles in MEMWR -> MemWrite=1 for 4 cycles, then state 0.
REQ-030 FETCH with memReady=0 for 2 cycles -> state stays 0, IRWrite=PCWrite=0; both go to 1 in the memReady=1 cycle, then state 1.
REQ-031 opcode 000001 -> illegalOp=1 in DECODE for exactly 1 cycle, then state 0; opcode 000101 behaves the same.
REQ-032 beq (000100) -> PCWriteCond=1, PCSource=01, AluOp=01 in state 8; j (000010) -> PCWrite=1, PCSource=10 in state 11.
REQ-033 reset asserted in MEMRD during a stall -> state 0 next edge, all outputs 0 except the FETCH selects, no RegWrite.
